// File: rtl/window_gen_pkg.sv
// Shared definitions for the window generator: state encoding, default widths, clamp helper.
package window_gen_pkg;

  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned N_W_DEF   = 8;
  localparam int unsigned ST_W      = 2;

  localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [ST_W-1:0] ST_DELAY = 2'd1;
  localparam logic [ST_W-1:0] ST_ON    = 2'd2;
  localparam logic [ST_W-1:0] ST_GAP   = 2'd3;

  // A programmed count of zero behaves as a count of one.
  function automatic logic [31:0] clamp1(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

endpackage

// File: rtl/wg_down_counter.sv
// Loadable down-counter; stops at zero and flags it combinationally.
module wg_down_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_zero_c
);

  logic [W-1:0] r_cnt;

  // Load has priority over decrement; no wrap below zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/window_gen.sv
// Trigger-driven burst generator: offset, then n_win windows of width high / gap low.
// Build option: WINDOW_GEN_RETRIG_EN makes a trigger edge during a burst restart it.
module window_gen
  import window_gen_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned N_W   = N_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             trig,
  input  logic [CNT_W-1:0] offset,
  input  logic [CNT_W-1:0] width,
  input  logic [CNT_W-1:0] gap,
  input  logic [N_W-1:0]   n_win,
  output logic             win,
  output logic             busy,
  output logic [N_W-1:0]   win_idx,
  output logic             done,
  output logic             trig_missed
);

  logic [ST_W-1:0]  r_state;
  logic [ST_W-1:0]  w_state_nxt;
  logic             r_trig_q;
  logic             w_trig_edge;
  logic             w_accept;
  logic             w_missed;
  logic [CNT_W-1:0] r_width;
  logic [CNT_W-1:0] r_gap;
  logic [N_W-1:0]   r_nwin;
  logic [CNT_W-1:0] w_width_cl;
  logic [CNT_W-1:0] w_gap_cl;
  logic [N_W-1:0]   w_nwin_cl;
  logic             w_cnt_load;
  logic [CNT_W-1:0] w_cnt_val;
  logic             w_cnt_zero;
  logic             w_last;
  logic             w_fin;
  logic             w_adv;
  logic             w_win_nxt;
  logic             w_busy_nxt;
  logic [N_W-1:0]   w_idx_nxt;

  assign w_width_cl  = CNT_W'(clamp1(32'(width)));
  assign w_gap_cl    = CNT_W'(clamp1(32'(gap)));
  assign w_nwin_cl   = N_W'(clamp1(32'(n_win)));
  assign w_trig_edge = trig & ~r_trig_q;
  assign w_last      = (win_idx == (r_nwin - N_W'(1)));

`ifdef WINDOW_GEN_RETRIG_EN
  assign w_accept = en & w_trig_edge;
  assign w_missed = 1'b0;
`else
  assign w_accept = en & w_trig_edge & (r_state == ST_IDLE);
  assign w_missed = en & w_trig_edge & (r_state != ST_IDLE);
`endif

  // Phase counter, reloaded at each phase entry.
  wg_down_counter #(.W(CNT_W)) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .i_en       (r_state != ST_IDLE),
    .o_zero_c   (w_cnt_zero)
  );

  // State register, trigger history and burst configuration latched at acceptance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_trig_q <= 1'b1;
      r_width  <= '0;
      r_gap    <= '0;
      r_nwin   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_trig_q <= trig;
      if (w_accept) begin
        r_width <= w_width_cl;
        r_gap   <= w_gap_cl;
        r_nwin  <= w_nwin_cl;
      end
    end
  end

  // Next-state logic and counter reload for each phase.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_load  = 1'b0;
    w_cnt_val   = '0;
    w_fin       = 1'b0;
    w_adv       = 1'b0;
    if (!en) begin
      w_state_nxt = ST_IDLE;
    end else if (w_accept) begin
      w_cnt_load = 1'b1;
      if (offset != '0) begin
        w_state_nxt = ST_DELAY;
        w_cnt_val   = offset - CNT_W'(1);
      end else begin
        w_state_nxt = ST_ON;
        w_cnt_val   = w_width_cl - CNT_W'(1);
      end
    end else begin
      case (r_state)
        ST_DELAY: begin
          if (w_cnt_zero) begin
            w_state_nxt = ST_ON;
            w_cnt_load  = 1'b1;
            w_cnt_val   = r_width - CNT_W'(1);
          end
        end
        ST_ON: begin
          if (w_cnt_zero) begin
            if (w_last) begin
              w_state_nxt = ST_IDLE;
              w_fin       = 1'b1;
            end else begin
              w_state_nxt = ST_GAP;
              w_cnt_load  = 1'b1;
              w_cnt_val   = r_gap - CNT_W'(1);
            end
          end
        end
        ST_GAP: begin
          if (w_cnt_zero) begin
            w_state_nxt = ST_ON;
            w_cnt_load  = 1'b1;
            w_cnt_val   = r_width - CNT_W'(1);
            w_adv       = 1'b1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output decode from the upcoming state, registered below.
  always_comb begin
    w_win_nxt  = (w_state_nxt == ST_ON);
    w_busy_nxt = (w_state_nxt != ST_IDLE);
    w_idx_nxt  = win_idx;
    if (w_accept) begin
      w_idx_nxt = '0;
    end else if (w_adv) begin
      w_idx_nxt = win_idx + N_W'(1);
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win         <= 1'b0;
      busy        <= 1'b0;
      win_idx     <= '0;
      done        <= 1'b0;
      trig_missed <= 1'b0;
    end else begin
      win         <= w_win_nxt;
      busy        <= w_busy_nxt;
      win_idx     <= w_idx_nxt;
      done        <= w_fin;
      trig_missed <= w_missed;
    end
  end

endmodule

// File: tb/tb_window_gen.sv
// Directed bench for window_gen; cycle-by-cycle bit patterns indexed by cycles after acceptance.
module tb_window_gen;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        trig;
  logic [15:0] offset;
  logic [15:0] width;
  logic [15:0] gap;
  logic [7:0]  n_win;
  logic        win;
  logic        busy;
  logic [7:0]  win_idx;
  logic        done;
  logic        trig_missed;

  int n_chk = 0;
  int n_bad = 0;
  logic [7:0] idx_log [0:31];

  window_gen dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .trig        (trig),
    .offset      (offset),
    .width       (width),
    .gap         (gap),
    .n_win       (n_win),
    .win         (win),
    .busy        (busy),
    .win_idx     (win_idx),
    .done        (done),
    .trig_missed (trig_missed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Raise trig, then check win/busy/done/trig_missed for cycles T+1..T+ncyc against bit k of
  // each pattern. retrig_at/enoff_at (0 = unused) raise trig / drop en during that cycle.
  task automatic run(input string nm, input int off, input int w, input int g, input int n,
                     input int ncyc, input int retrig_at, input int enoff_at,
                     input logic [31:0] pw, input logic [31:0] pb,
                     input logic [31:0] pd, input logic [31:0] pm);
    offset = 16'(off);
    width  = 16'(w);
    gap    = 16'(g);
    n_win  = 8'(n);
    trig   = 1'b1;
    step();
    for (int k = 1; k <= ncyc; k++) begin
      chk($sformatf("%s win T+%0d", nm, k), 32'(win), 32'(pw[k]));
      chk($sformatf("%s busy T+%0d", nm, k), 32'(busy), 32'(pb[k]));
      chk($sformatf("%s done T+%0d", nm, k), 32'(done), 32'(pd[k]));
      chk($sformatf("%s missed T+%0d", nm, k), 32'(trig_missed), 32'(pm[k]));
      idx_log[k] = win_idx;
      if (k == 1) begin
        trig = 1'b0;
        if (retrig_at == 0) begin
          offset = 16'd7;
          width  = 16'd9;
          gap    = 16'd5;
          n_win  = 8'd1;
        end
      end
      if (k == retrig_at)     trig = 1'b1;
      if (k == retrig_at + 1) trig = 1'b0;
      if (k == enoff_at)      en = 1'b0;
      if (k == enoff_at + 1)  en = 1'b1;
      step();
    end
    trig = 1'b0;
    en   = 1'b1;
    step();
    step();
  endtask

  initial begin
    rst_n  = 1'b0;
    en     = 1'b1;
    trig   = 1'b1;
    offset = '0;
    width  = '0;
    gap    = '0;
    n_win  = '0;
    step();
    step();
    step();
    chk("rst win", 32'(win), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst missed", 32'(trig_missed), 32'd0);
    chk("rst idx", 32'(win_idx), 32'd0);

    // Trigger held high across reset release must not start a burst.
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("held trig busy %0d", i), 32'(busy), 32'd0);
      chk($sformatf("held trig win %0d", i), 32'(win), 32'd0);
    end
    trig = 1'b0;
    step();
    run("retrigger", 0, 2, 1, 1, 5, 0, 0, 32'h6, 32'h6, 32'h8, 32'h0);

    // Three windows after an offset; config changes after T must not matter.
    run("burst3", 3, 4, 2, 3, 22, 0, 0, 32'h000F3CF0, 32'h000FFFFE, 32'h00100000, 32'h0);
    chk("burst3 idx T+5", 32'(idx_log[5]), 32'd0);
    chk("burst3 idx T+9", 32'(idx_log[9]), 32'd0);
    chk("burst3 idx T+10", 32'(idx_log[10]), 32'd1);
    chk("burst3 idx T+15", 32'(idx_log[15]), 32'd1);
    chk("burst3 idx T+16", 32'(idx_log[16]), 32'd2);
    chk("burst3 idx T+22", 32'(idx_log[22]), 32'd2);

    // All-zero config clamps to one single-cycle window.
    run("zeros", 0, 0, 0, 0, 4, 0, 0, 32'h2, 32'h2, 32'h4, 32'h0);

    // Second trigger edge at T+6.
`ifdef WINDOW_GEN_RETRIG_EN
    run("edge busy", 3, 4, 2, 3, 27, 6, 0, 32'h03CF3C70, 32'h03FFFFFE, 32'h04000000, 32'h0);
    chk("edge busy idx T+10", 32'(idx_log[10]), 32'd0);
`else
    run("edge busy", 3, 4, 2, 3, 22, 6, 0, 32'h000F3CF0, 32'h000FFFFE, 32'h00100000, 32'h80);
    chk("edge busy idx T+10", 32'(idx_log[10]), 32'd1);
`endif

    // en low during T+5 aborts; no done; next edge accepted normally.
    run("enable abort", 3, 4, 2, 3, 22, 0, 5, 32'h30, 32'h3E, 32'h0, 32'h0);
    run("after abort", 0, 0, 0, 0, 4, 0, 0, 32'h2, 32'h2, 32'h4, 32'h0);

    // Reset in the middle of window 1.
    offset = 16'd3;
    width  = 16'd4;
    gap    = 16'd2;
    n_win  = 8'd3;
    trig   = 1'b1;
    step();
    trig = 1'b0;
    for (int k = 2; k <= 11; k++) step();
    chk("mid-on win", 32'(win), 32'd1);
    chk("mid-on idx", 32'(win_idx), 32'd1);
    rst_n = 1'b0;
    step();
    chk("mid rst win", 32'(win), 32'd0);
    chk("mid rst busy", 32'(busy), 32'd0);
    chk("mid rst idx", 32'(win_idx), 32'd0);
    chk("mid rst done", 32'(done), 32'd0);
    rst_n = 1'b1;
    step();
    step();
    chk("post rst busy", 32'(busy), 32'd0);
    run("after reset", 0, 0, 0, 0, 4, 0, 0, 32'h2, 32'h2, 32'h4, 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
